// File: rtl/rv32_pkg.sv
// Shared RV32 core constants and the write-arbiter state encoding.
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Requester indices on the register-file write port.
    localparam logic WB_PORT = 1'b0;
    localparam logic MC_PORT = 1'b1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } wr_arb_state_t;

endpackage

// File: rtl/rr_starve_counter.sv
// Purpose: counts consecutive cycles the multi-cycle port is stalled; flags when it must win.
// Latency: force_p1 is a registered count compared combinationally, valid the cycle after the stall.
// Backpressure: none of its own; clears whenever port 1 is accepted or withdraws its request.
module rr_starve_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic p1_valid,
    input  logic p1_ready,
    output logic force_p1
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] wait_cnt;

    // Only stalls seen while arbitrating count, so the clear sequence never pre-loads it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (!run || !p1_valid || p1_ready) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign force_p1 = (wait_cnt == CNT_MAX);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Purpose: shares the register-file write port between writeback (p0) and the multi-cycle unit (p1); clears x1..x31 after reset.
// Latency: accept in cycle N drives rf_we/rf_a3/rf_wd3 in cycle N+1.
// Backpressure: p0 has priority; p1 is forced ahead after MAX_WAIT stalled cycles; both readies low during the clear sequence.
module regfile_write_arbiter #(
    parameter int XLEN     = rv32_pkg::XLEN,
    parameter int NREGS    = 32,
    parameter int MAX_WAIT = 4,
    parameter logic [XLEN-1:0] INIT_VALUE = '0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            p0_valid,
    input  logic [rv32_pkg::REG_ADDR_W-1:0] p0_addr,
    input  logic [XLEN-1:0]                 p0_data,
    output logic                            p0_ready,
    input  logic                            p1_valid,
    input  logic [rv32_pkg::REG_ADDR_W-1:0] p1_addr,
    input  logic [XLEN-1:0]                 p1_data,
    output logic                            p1_ready,
    output logic                            rf_we,
    output logic [rv32_pkg::REG_ADDR_W-1:0] rf_a3,
    output logic [XLEN-1:0]                 rf_wd3,
    output logic                            init_done,
    output logic [rv32_pkg::REG_ADDR_W-1:0] p1_pending_addr
);

    import rv32_pkg::*;

    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NREGS - 1);

    wr_arb_state_t         state_q;
    logic [REG_ADDR_W-1:0] clr_idx;
    logic                  force_p1;
    logic                  grant_port;
    logic                  accept;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] win_addr;
    logic [XLEN-1:0]       win_data;

    rr_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (state_q == RUN),
        .p1_valid (p1_valid),
        .p1_ready (p1_ready),
        .force_p1 (force_p1)
    );

    always_comb begin
        p0_ready = 1'b0;
        p1_ready = 1'b0;
        if (state_q == RUN) begin
            p1_ready = p1_valid && (!p0_valid || force_p1);
            p0_ready = p0_valid && !p1_ready;
        end
    end

    assign grant_port      = p1_ready ? MC_PORT : WB_PORT;
    assign accept          = p0_ready || p1_ready;
    assign win_addr        = (grant_port == MC_PORT) ? p1_addr : p0_addr;
    assign win_data        = (grant_port == MC_PORT) ? p1_data : p0_data;
    // x0 is hardwired zero: the transfer completes but nothing reaches the register file.
    assign wr_en           = accept && (win_addr != '0);
    assign p1_pending_addr = (p1_valid && !p1_ready) ? p1_addr : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_idx   <= REG_ADDR_W'(1);
            rf_we     <= 1'b0;
            rf_a3     <= '0;
            rf_wd3    <= '0;
            init_done <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    rf_we  <= 1'b1;
                    rf_a3  <= clr_idx;
                    rf_wd3 <= INIT_VALUE;
                    if (clr_idx == LAST_IDX) begin
                        state_q   <= RUN;
                        init_done <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                RUN: begin
                    rf_we <= wr_en;
                    if (wr_en) begin
                        rf_a3  <= win_addr;
                        rf_wd3 <= win_data;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    rf_we   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        p0_valid = 1'b0;
    logic [4:0]  p0_addr = '0;
    logic [31:0] p0_data = '0;
    logic        p0_ready;
    logic        p1_valid = 1'b0;
    logic [4:0]  p1_addr = '0;
    logic [31:0] p1_data = '0;
    logic        p1_ready;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic        init_done;
    logic [4:0]  p1_pending_addr;

    int          n_cmp = 0;
    int          n_bad = 0;
    wr_t         exp_q[$];
    logic [31:0] shadow [32];

    regfile_write_arbiter #(
        .XLEN       (32),
        .NREGS      (32),
        .MAX_WAIT   (4),
        .INIT_VALUE (32'd0)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .p0_valid        (p0_valid),
        .p0_addr         (p0_addr),
        .p0_data         (p0_data),
        .p0_ready        (p0_ready),
        .p1_valid        (p1_valid),
        .p1_addr         (p1_addr),
        .p1_data         (p1_data),
        .p1_ready        (p1_ready),
        .rf_we           (rf_we),
        .rf_a3           (rf_a3),
        .rf_wd3          (rf_wd3),
        .init_done       (init_done),
        .p1_pending_addr (p1_pending_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got a3=%0d wd3=%h, expected no write (t=%0t)", rf_a3, rf_wd3, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write.a3", {27'd0, rf_a3}, {27'd0, e.a});
                chk("write.wd3", rf_wd3, e.d);
            end
            shadow[rf_a3] = rf_wd3;
        end
    end

    task automatic cyc(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic e0, input logic e1, input logic [4:0] ep, input string tag);
        @(posedge clk);
        #1;
        p0_valid = v0; p0_addr = a0; p0_data = d0;
        p1_valid = v1; p1_addr = a1; p1_data = d1;
        @(negedge clk);
        chk({tag, ".p0_ready"}, {31'd0, p0_ready}, {31'd0, e0});
        chk({tag, ".p1_ready"}, {31'd0, p1_ready}, {31'd0, e1});
        chk({tag, ".pending"}, {27'd0, p1_pending_addr}, {27'd0, ep});
        if (e0 && a0 != 5'd0) exp_q.push_back('{a0, d0});
        if (e1 && a1 != 5'd0) exp_q.push_back('{a1, d1});
    endtask

    task automatic idle(input string tag);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, tag);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".rf_we"}, {31'd0, rf_we}, 32'd0);
        chk({tag, ".rf_a3"}, {27'd0, rf_a3}, 32'd0);
        chk({tag, ".rf_wd3"}, rf_wd3, 32'd0);
        chk({tag, ".init_done"}, {31'd0, init_done}, 32'd0);
        chk({tag, ".p0_ready"}, {31'd0, p0_ready}, 32'd0);
        chk({tag, ".p1_ready"}, {31'd0, p1_ready}, 32'd0);
    endtask

    // Queues n clear writes, releases reset on a falling edge, then watches n cycles of CLEAR.
    task automatic clear_run(input int n, input logic hold_valid);
        for (int k = 1; k <= n; k++) exp_q.push_back('{5'(k), 32'd0});
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk("clear.rf_we", {31'd0, rf_we}, 32'd1);
            chk("clear.init_done", {31'd0, init_done}, (k == 31) ? 32'd1 : 32'd0);
            chk("clear.p0_ready", {31'd0, p0_ready}, 32'd0);
            chk("clear.p1_ready", {31'd0, p1_ready}, 32'd0);
            if (hold_valid && k <= 30)
                chk("clear.pending", {27'd0, p1_pending_addr}, 32'd3);
            if (hold_valid && k == 30) begin
                p0_valid = 1'b0;
                p1_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #1 reset_n = 1'b0;
        @(negedge clk);
        check_reset("reset");
        clear_run(31, 1'b0);

        // Single writeback request.
        cyc(1'b1, 5'd5, 32'h00008000, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, "wb_single");
        idle("idle1");

        // Both ports valid: four p0 grants, then p1 forced ahead, twice.
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 5'd4, 32'd1, 1'b1, 5'd6, 32'd2,
                (i % 5) != 4, (i % 5) == 4, ((i % 5) != 4) ? 5'd6 : 5'd0, "starve");
        idle("idle2");

        // p1 withdrawing its request resets the wait count.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 5'd4, 32'd3, 1'b1, 5'd6, 32'd4, 1'b1, 1'b0, 5'd6, "pre_drop");
        cyc(1'b1, 5'd4, 32'd5, 1'b0, 5'd6, 32'd4, 1'b1, 1'b0, 5'd0, "drop");
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 5'd4, 32'd3, 1'b1, 5'd6, 32'd4, i != 4, i == 4, (i != 4) ? 5'd6 : 5'd0, "post_drop");
        idle("idle3");

        // Same destination: p0 lands first, p1 second, last write wins.
        cyc(1'b1, 5'd7, 32'd10, 1'b1, 5'd7, 32'd20, 1'b1, 1'b0, 5'd7, "same_a");
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd20, 1'b0, 1'b1, 5'd0, "same_b");
        idle("idle4");
        idle("idle5");
        chk("same.final_x7", shadow[7], 32'd20);

        // x0 write is accepted but never reaches the register file.
        cyc(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, "x0");
        idle("idle6");
        chk("x0.rf_we", {31'd0, rf_we}, 32'd0);

        // Reset with an accepted write in flight: the write is dropped.
        cyc(1'b1, 5'd11, 32'h55, 1'b1, 5'd3, 32'h66, 1'b1, 1'b0, 5'd3, "inflight");
        exp_q.delete(exp_q.size() - 1);
        #2 reset_n = 1'b0;
        #1 check_reset("abort_run");
        chk("abort_run.pending", {27'd0, p1_pending_addr}, 32'd3);
        @(posedge clk);
        #1 chk("abort_run.dropped", {31'd0, rf_we}, 32'd0);
        p0_valid = 1'b0;
        p1_valid = 1'b0;

        // Abort CLEAR after x12 is issued, then a full clear with requests pending.
        clear_run(12, 1'b0);
        #2 reset_n = 1'b0;
        #1 check_reset("abort_clear");
        p0_valid = 1'b1; p0_addr = 5'd9;  p0_data = 32'h99;
        p1_valid = 1'b1; p1_addr = 5'd3;  p1_data = 32'h33;
        clear_run(31, 1'b1);

        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hABCD, 1'b0, 1'b1, 5'd0, "p1_only");
        idle("idle7");
        idle("idle8");
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
